// File: rtl/sseg_pkg.sv
// Seven-segment definitions shared by the scan driver and its decoder:
// bit positions within {DP,g,f,e,d,c,b,a}, the hex glyph table and the slot phase.
package sseg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high gfedcba glyphs for 0..9, A, b, C, d, E, F.
    localparam logic [6:0] SEG_CODES [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic {
        SLOT_DARK,
        SLOT_LIT
    } slot_phase_e;

    function automatic logic [7:0] seg_pack(input logic dp, input logic [6:0] gfedcba);
        logic [7:0] s;
        s         = '0;
        s[SEG_A]  = gfedcba[SEG_A];
        s[SEG_B]  = gfedcba[SEG_B];
        s[SEG_C]  = gfedcba[SEG_C];
        s[SEG_D]  = gfedcba[SEG_D];
        s[SEG_E]  = gfedcba[SEG_E];
        s[SEG_F]  = gfedcba[SEG_F];
        s[SEG_G]  = gfedcba[SEG_G];
        s[SEG_DP] = dp;
        return s;
    endfunction

endpackage

// File: rtl/multiplexed_sseg_driver_if.sv
// Display data bundle between a controller (master) and the multiplexed
// seven-segment driver (slave).
interface multiplexed_sseg_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    En;
    logic [4*NUM_DIGITS-1:0] Hex;
    logic [NUM_DIGITS-1:0]   DP;
    logic [NUM_DIGITS-1:0]   Blank;
    logic                    LZS;
    logic [7:0]              SSeg;
    logic [NUM_DIGITS-1:0]   Anode;
    logic                    FrameTick;

    modport master (
        output En, Hex, DP, Blank, LZS,
        input  SSeg, Anode, FrameTick
    );

    modport slave (
        input  En, Hex, DP, Blank, LZS,
        output SSeg, Anode, FrameTick
    );
endinterface

// File: rtl/hex_to_7seg_decoder.sv
// Combinational nibble-to-glyph lookup; output is active-high {DP,g,f,e,d,c,b,a}.
module hex_to_7seg_decoder
    import sseg_pkg::*;
(
    input  logic [3:0] Hex,
    input  logic       DP,
    output logic [7:0] SSeg
);

    assign SSeg = seg_pack(DP, SEG_CODES[Hex]);

endmodule

// File: rtl/multiplexed_sseg_driver.sv
// Time-multiplexed seven-segment scanner: one digit per PRESCALE-cycle slot,
// dark guard at the start of every slot, frame-synchronous shadow data.
module multiplexed_sseg_driver
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000,
    parameter int DEADTIME   = 2,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    Clk,
    input  logic                    nRst,
    input  logic                    En,
    input  logic [4*NUM_DIGITS-1:0] Hex,
    input  logic [NUM_DIGITS-1:0]   DP,
    input  logic [NUM_DIGITS-1:0]   Blank,
    input  logic                    LZS,
    output logic [7:0]              SSeg,
    output logic [NUM_DIGITS-1:0]   Anode,
    output logic                    FrameTick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic INV = (ACTIVE_LOW != 0);
    localparam logic [7:0]            SEG_OFF  = {8{INV}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{INV}};
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic                    need_load;
    logic [4*NUM_DIGITS-1:0] sh_hex;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic                    sh_lzs;
    logic                    slot_end;
    logic                    frame_end;
    logic                    load_now;
    logic [4*NUM_DIGITS-1:0] cur_hex;
    logic [NUM_DIGITS-1:0]   cur_dp;
    logic [NUM_DIGITS-1:0]   cur_blank;
    logic                    cur_lzs;
    logic [NUM_DIGITS-1:0]   suppress;
    logic [3:0]              digit_hex;
    logic                    digit_dp;
    logic                    digit_blank;
    logic                    digit_supp;
    logic [7:0]              decoded;
    logic [7:0]              digit_seg;
    logic [NUM_DIGITS-1:0]   anode_hot;
    logic                    dark;
    slot_phase_e             phase;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign load_now  = En && (need_load || frame_end);
    assign FrameTick = En && frame_end;

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            cnt <= '0;
            idx <= '0;
        end else if (En) begin
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            need_load <= 1'b1;
            sh_hex    <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
            sh_lzs    <= 1'b0;
        end else if (load_now) begin
            need_load <= 1'b0;
            sh_hex    <= Hex;
            sh_dp     <= DP;
            sh_blank  <= Blank;
            sh_lzs    <= LZS;
        end
    end

    // The first frame after reset is shown from the live inputs, since its
    // shadow copy is only being taken during that very cycle.
    assign cur_hex   = need_load ? Hex   : sh_hex;
    assign cur_dp    = need_load ? DP    : sh_dp;
    assign cur_blank = need_load ? Blank : sh_blank;
    assign cur_lzs   = need_load ? LZS   : sh_lzs;

    always_comb begin : lead_zero
        logic zero_run;
        zero_run = 1'b1;
        suppress = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (cur_hex[4*i +: 4] == 4'h0);
            if (i != 0) begin
                suppress[i] = cur_lzs && zero_run;
            end
        end
    end

    always_comb begin
        digit_hex   = 4'h0;
        digit_dp    = 1'b0;
        digit_blank = 1'b0;
        digit_supp  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                digit_hex   = cur_hex[4*i +: 4];
                digit_dp    = cur_dp[i];
                digit_blank = cur_blank[i];
                digit_supp  = suppress[i];
            end
        end
    end

    hex_to_7seg_decoder u_decoder (
        .Hex  (digit_hex),
        .DP   (digit_dp),
        .SSeg (decoded)
    );

    // A suppressed leading zero keeps its decimal point; Blank kills everything.
    always_comb begin
        digit_seg = decoded;
        if (digit_blank) begin
            digit_seg = 8'h00;
        end else if (digit_supp) begin
            digit_seg = seg_pack(digit_dp, 7'h00);
        end
    end

    assign anode_hot = NUM_DIGITS'(1) << idx;

    if (DEADTIME > 0) begin : g_dead
        assign dark = (cnt < CNT_W'(DEADTIME));
    end else begin : g_nodead
        assign dark = 1'b0;
    end

    assign phase = dark ? SLOT_DARK : SLOT_LIT;

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            SSeg  <= SEG_OFF;
            Anode <= AN_OFF;
        end else if (!En || phase == SLOT_DARK) begin
            SSeg  <= SEG_OFF;
            Anode <= AN_OFF;
        end else begin
            SSeg  <= digit_seg ^ SEG_OFF;
            Anode <= anode_hot ^ AN_OFF;
        end
    end

endmodule

// File: tb/tb_multiplexed_sseg_driver.sv
// Self-checking bench: frame-arithmetic reference model compared every cycle,
// directed literal scenarios, then a randomized run.
module tb_multiplexed_sseg_driver;

    localparam int NUM_DIGITS = 4;
    localparam int PRESCALE   = 4;
    localparam int DEADTIME   = 1;
    localparam int ACTIVE_LOW = 1;
    localparam int FRAME      = NUM_DIGITS * PRESCALE;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic Clk  = 1'b0;
    logic nRst = 1'b0;
    int   testsRun    = 0;
    int   testsFailed = 0;
    bit   started     = 1'b0;

    multiplexed_sseg_driver_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

    multiplexed_sseg_driver #(
        .NUM_DIGITS (NUM_DIGITS),
        .PRESCALE   (PRESCALE),
        .DEADTIME   (DEADTIME),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) dut (
        .Clk       (Clk),
        .nRst      (nRst),
        .En        (bus.En),
        .Hex       (bus.Hex),
        .DP        (bus.DP),
        .Blank     (bus.Blank),
        .LZS       (bus.LZS),
        .SSeg      (bus.SSeg),
        .Anode     (bus.Anode),
        .FrameTick (bus.FrameTick)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %02h, expected %02h at %0t", name, actual, expected, $time);
        end
    endtask

    // Active-high glyph a digit must show, given one frame's data.
    function automatic logic [7:0] segFor(input logic [15:0] h, input logic [3:0] dp,
                                          input logic [3:0] blank, input logic lzs, input int digit);
        logic [3:0] nib;
        if (blank[digit]) return 8'h00;
        nib = 4'(h >> (4 * digit));
        if (lzs && digit != 0 && (h >> (4 * digit)) == 16'h0) return {dp[digit], 7'h00};
        return {dp[digit], GLYPH[nib]};
    endfunction

    int          enCycles  = 0;
    bit          needLoad  = 1'b1;
    logic [15:0] snapHex   = '0;
    logic [3:0]  snapDp    = '0;
    logic [3:0]  snapBlank = '0;
    logic        snapLzs   = 1'b0;
    logic [7:0]  expSeg    = 8'hFF;
    logic [3:0]  expAn     = 4'hF;

    // Position in the scan is simply the number of enabled cycles since reset.
    always @(posedge Clk or negedge nRst) begin : model
        logic [15:0] h;
        logic [3:0]  d;
        logic [3:0]  b;
        logic        z;
        int          slot;
        int          digit;
        if (!nRst) begin
            enCycles  <= 0;
            needLoad  <= 1'b1;
            snapHex   <= '0;
            snapDp    <= '0;
            snapBlank <= '0;
            snapLzs   <= 1'b0;
            expSeg    <= 8'hFF;
            expAn     <= 4'hF;
        end else if (!bus.En) begin
            expSeg <= 8'hFF;
            expAn  <= 4'hF;
        end else begin
            h = needLoad ? bus.Hex   : snapHex;
            d = needLoad ? bus.DP    : snapDp;
            b = needLoad ? bus.Blank : snapBlank;
            z = needLoad ? bus.LZS   : snapLzs;
            slot  = enCycles % PRESCALE;
            digit = (enCycles / PRESCALE) % NUM_DIGITS;
            if (slot < DEADTIME) begin
                expSeg <= 8'hFF;
                expAn  <= 4'hF;
            end else begin
                expSeg <= ~segFor(h, d, b, z, digit);
                expAn  <= ~(4'b0001 << digit);
            end
            if (needLoad || (enCycles % FRAME) == FRAME - 1) begin
                snapHex   <= bus.Hex;
                snapDp    <= bus.DP;
                snapBlank <= bus.Blank;
                snapLzs   <= bus.LZS;
            end
            needLoad <= 1'b0;
            enCycles <= enCycles + 1;
        end
    end

    always @(negedge Clk) begin
        if (started) begin
            checkOutput("model_sseg", bus.SSeg, expSeg);
            checkOutput("model_anode", 8'(bus.Anode), 8'(expAn));
            checkOutput("model_frametick", 8'(bus.FrameTick),
                        8'(bus.En && nRst && ((enCycles % FRAME) == FRAME - 1)));
        end
    end

    task automatic applyStimulus(input logic [15:0] hex, input logic [3:0] dp,
                                 input logic [3:0] blank, input logic lzs);
        @(posedge Clk);
        #3;
        nRst      = 1'b0;
        bus.En    = 1'b0;
        bus.Hex   = hex;
        bus.DP    = dp;
        bus.Blank = blank;
        bus.LZS   = lzs;
        @(posedge Clk);
        #3;
        nRst   = 1'b1;
        bus.En = 1'b1;
        @(posedge Clk);
    endtask

    // Literal slot-by-slot expectations; segsA/segsB pack {d3,d2,d1,d0}.
    task automatic runFrames(input string tag, input int nCycles, input logic [31:0] segsA,
                             input logic [31:0] segsB, input int changeAt,
                             input logic [15:0] newHex, output int ticks);
        int         slot;
        int         digit;
        logic [3:0] an;
        logic [7:0] sg;
        ticks = 0;
        for (int j = 0; j < nCycles; j++) begin
            @(negedge Clk);
            slot  = j % PRESCALE;
            digit = (j / PRESCALE) % NUM_DIGITS;
            if (slot < DEADTIME) begin
                checkOutput({tag, "_dark_anode"}, 8'(bus.Anode), 8'h0F);
                checkOutput({tag, "_dark_sseg"}, bus.SSeg, 8'hFF);
            end else begin
                an = ~(4'b0001 << digit);
                sg = (j < FRAME) ? segsA[8*digit +: 8] : segsB[8*digit +: 8];
                checkOutput({tag, "_anode"}, 8'(bus.Anode), 8'(an));
                checkOutput({tag, "_sseg"}, bus.SSeg, sg);
            end
            if (bus.FrameTick) ticks++;
            if (j == changeAt) begin
                #2;
                bus.Hex = newHex;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ticks;
        bus.En    = 1'b0;
        bus.Hex   = '0;
        bus.DP    = '0;
        bus.Blank = '0;
        bus.LZS   = 1'b0;
        repeat (3) @(posedge Clk);
        #3;
        started = 1'b1;
        @(negedge Clk);
        checkOutput("reset_sseg", bus.SSeg, 8'hFF);
        checkOutput("reset_anode", 8'(bus.Anode), 8'h0F);
        checkOutput("reset_frametick", 8'(bus.FrameTick), 8'h00);

        applyStimulus(16'h12AF, 4'b0000, 4'b0000, 1'b0);
        runFrames("scan", 2 * FRAME, 32'hF9A4888E, 32'hF9A4888E, -1, 16'h0000, ticks);
        checkOutput("scan_frameticks", 8'(ticks), 8'd2);

        @(posedge Clk);
        #3;
        nRst = 1'b0;
        #1;
        checkOutput("midreset_sseg", bus.SSeg, 8'hFF);
        checkOutput("midreset_anode", 8'(bus.Anode), 8'h0F);
        @(posedge Clk);
        #3;
        nRst = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        checkOutput("postreset_dark_anode", 8'(bus.Anode), 8'h0F);
        @(negedge Clk);
        checkOutput("postreset_first_anode", 8'(bus.Anode), 8'h0E);
        checkOutput("postreset_first_sseg", bus.SSeg, 8'h8E);

        applyStimulus(16'h0000, 4'b0100, 4'b0000, 1'b1);
        runFrames("lzs", FRAME, 32'hFF7FFFC0, 32'hFF7FFFC0, -1, 16'h0000, ticks);

        applyStimulus(16'h1111, 4'b0000, 4'b0000, 1'b0);
        runFrames("tear", 2 * FRAME, 32'hF9F9F9F9, 32'hA4A4A4A4, 5, 16'h2222, ticks);

        applyStimulus(16'h12AF, 4'b0000, 4'b0010, 1'b0);
        runFrames("blank", FRAME, 32'hF9A4FF8E, 32'hF9A4FF8E, -1, 16'h0000, ticks);
        repeat (FRAME - 1) @(posedge Clk);
        #3;
        bus.En = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge Clk);
            @(negedge Clk);
            checkOutput("frozen_sseg", bus.SSeg, 8'hFF);
            checkOutput("frozen_anode", 8'(bus.Anode), 8'h0F);
            checkOutput("frozen_frametick", 8'(bus.FrameTick), 8'h00);
        end
        #1;
        bus.En = 1'b1;
        #1;
        checkOutput("resume_frametick", 8'(bus.FrameTick), 8'h01);
        @(negedge Clk);
        checkOutput("resume_anode", 8'(bus.Anode), 8'h07);
        checkOutput("resume_sseg", bus.SSeg, 8'hF9);
        checkOutput("resume_tick_clear", 8'(bus.FrameTick), 8'h00);
        @(negedge Clk);
        checkOutput("resume_dark_anode", 8'(bus.Anode), 8'h0F);
        @(negedge Clk);
        checkOutput("resume_next_anode", 8'(bus.Anode), 8'h0E);
        checkOutput("resume_next_sseg", bus.SSeg, 8'h8E);

        for (int n = 0; n < 1500; n++) begin
            @(posedge Clk);
            #3;
            nRst   = ($urandom_range(0, 99) >= 2);
            bus.En = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    bus.Hex[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                end
                bus.DP    = 4'($urandom);
                bus.Blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                bus.LZS   = 1'($urandom);
            end
        end
        @(posedge Clk);
        #3;
        nRst   = 1'b1;
        bus.En = 1'b1;
        repeat (2 * FRAME) @(posedge Clk);
        @(negedge Clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
